ntt_conf_sequencer: RTL and testbench
=====================================

Name: ntt_conf_sequencer

Overview:
- Top-level operation sequencer for the mixed-radix 512-point NTT/INTT core.
- Takes a single start/mode request and drives the 4-bit conf input of the stage FSM through the full multi-stage run:
  - NTT: radix-2 stage, then the radix-4 stages.
  - INTT: radix-4 stages, then the radix-2 stage.
- Watches done_flag to advance, holds a DONE state long enough for the butterfly/write pipeline to drain, then reports completion.
- Also provides abort and a per-stage watchdog.

Parameters:
- DRAIN_R2, 10: cycles held in DONE_RADIX2_* before advancing. Must cover the radix-2 write-enable delay of 8 plus margin; must be ≥2.
- DRAIN_R4, 16: cycles held in DONE_RADIX4_* before advancing. Must cover the radix-4 write-enable delay of 14 plus margin; must be ≥2.
- TIMEOUT, 1024: maximum cycles in any RUN state without the expected done_flag before an error abort.
- CNT_W, 11: width of the shared drain/watchdog counter. Must satisfy 2^CNT_W > max(TIMEOUT, DRAIN_R2, DRAIN_R4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to begin an operation; sampled only in S_IDLE
- mode  in  1  0 = forward NTT, 1 = INTT; captured with start
- abort  in  1  synchronous abort; returns to idle
- done_flag  in  3  stage completion code from the stage FSM
- conf  out  4  configuration code to the stage FSM, registered
- busy  out  1  high from the cycle after an accepted start until the cycle done or err pulses
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on watchdog expiry
- stage_id  out  2  current step index, 0..3, for debug/status

Behaviour:
- Conf codes:
  - IDLE=0000, R2_NTT=0001, R4_NTT=0010
  - DONE_R2_NTT=0011, DONE_R4_NTT=0100
  - R4_INTT=0101, R2_INTT=0110
  - DONE_R2_INTT=0111, DONE_R4_INTT=1000
- Done codes: R2_NTT=001, R4_NTT=010, R4_INTT=011, R2_INTT=100.
- Reset (synchronous, any state): conf=IDLE, busy=0, done=0, err=0, stage_id=0, counter=0, mode register=0.
- States: S_IDLE, S_RUN_A, S_DRAIN_A, S_RUN_B, S_DRAIN_B, S_GAP.
  - conf is a registered decode of state plus mode_q.
  - NTT (mode_q=0): RUN_A=R2_NTT, DRAIN_A=DONE_R2_NTT, RUN_B=R4_NTT, DRAIN_B=DONE_R4_NTT.
  - INTT (mode_q=1): RUN_A=R4_INTT, DRAIN_A=DONE_R4_INTT, RUN_B=R2_INTT, DRAIN_B=DONE_R2_INTT.
  - stage_id: IDLE=0, RUN_A/DRAIN_A=1, RUN_B/DRAIN_B=2, GAP=3.
- S_IDLE: on start=1, capture mode_q and go to S_RUN_A. conf and busy change on the edge after start (latency 1).
- S_RUN_*: counter increments each cycle.
  - done_flag equal to the expected code for the current stage/mode: go to S_DRAIN_*, clear counter. conf becomes the DONE_* code on the next edge.
  - Any other nonzero done_flag value is ignored.
  - Counter reaches TIMEOUT-1 without a match: go to S_IDLE, pulse err, drop busy.
- S_DRAIN_*: counter increments; at DRAIN_x-1 advance. DRAIN_x is the drain length for the radix of the stage just finished.
  - S_DRAIN_A advances to S_RUN_B.
  - S_DRAIN_B advances to S_GAP.
  - done_flag is ignored in drain states.
  - The stage FSM sees a non-run conf for ≥2 cycles, so its i/j/k/p counters reinitialise before the next run.
- S_GAP: one cycle with conf=IDLE; then S_IDLE. done pulses in the S_GAP→S_IDLE cycle; busy falls in the same cycle.
- abort=1 in any non-idle state: next edge goes to S_IDLE, conf=IDLE, busy=0, no done, no err.
  - abort has priority over done_flag match, drain expiry and timeout in the same cycle.
  - abort in S_IDLE is a no-op, and abort wins over a simultaneous start.
- start while busy is ignored (no queueing). mode is only sampled with an accepted start.
- done and err are mutually exclusive and never high for more than 1 cycle.

Decomposition:
- Shared package ntt_ctrl_pkg holds:
  - the nine conf code localparams and four done_flag code localparams (single source for this block and the stage FSM);
  - the state encoding.
- Sub-module seq_cycle_counter: CNT_W-bit counter with sync clear, increment enable and compare-to-limit output. One instance is shared by drain and watchdog, because the two are never active together.

Test Plan:
- NTT: mode=0, start pulse. Bench stub returns done_flag=001 after 130 cycles of conf=0001 and 010 after 300 cycles of conf=0010. Required:
  - conf sequence 0001→0011 (held 10 cycles)→0010→0100 (held 16 cycles)→0000;
  - done pulses once; busy high throughout and low in the done cycle.
- INTT: mode=1. Required conf sequence 0101→1000 (16 cycles)→0110→0111 (10 cycles)→0000, on done_flag=011 then 100; done once.
- Wrong code: in R2_NTT the stub drives 010 for 5 cycles, then 001. Required: conf stays 0001 until 001, then DONE_R2_NTT.
- Watchdog: the stub never asserts done_flag. Required: exactly TIMEOUT cycles after entering RUN_A, err pulses 1 cycle, conf=0000, busy=0, done never asserted.
- Abort: abort during DRAIN_A coincident with drain expiry. Required: next cycle conf=0000, busy=0, no done/err. A start the following cycle begins a fresh run with conf=0001.
- Reset and start-while-busy: rst asserted mid-RUN_B forces all outputs to reset values on the next edge. A start pulse during RUN_A leaves the sequence unchanged and done still pulses exactly once.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// Shared NTT control definitions: conf codes driven to the stage FSM, done_flag
// codes it returns, and the operation sequencer state encoding.
package ntt_ctrl_pkg;

    typedef logic [3:0] conf_t;
    typedef logic [2:0] flag_t;

    localparam conf_t CONF_IDLE         = 4'b0000;
    localparam conf_t CONF_R2_NTT       = 4'b0001;
    localparam conf_t CONF_R4_NTT       = 4'b0010;
    localparam conf_t CONF_DONE_R2_NTT  = 4'b0011;
    localparam conf_t CONF_DONE_R4_NTT  = 4'b0100;
    localparam conf_t CONF_R4_INTT      = 4'b0101;
    localparam conf_t CONF_R2_INTT      = 4'b0110;
    localparam conf_t CONF_DONE_R2_INTT = 4'b0111;
    localparam conf_t CONF_DONE_R4_INTT = 4'b1000;

    localparam flag_t DF_NONE    = 3'b000;
    localparam flag_t DF_R2_NTT  = 3'b001;
    localparam flag_t DF_R4_NTT  = 3'b010;
    localparam flag_t DF_R4_INTT = 3'b011;
    localparam flag_t DF_R2_INTT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN_A   = 3'd1,
        S_DRAIN_A = 3'd2,
        S_RUN_B   = 3'd3,
        S_DRAIN_B = 3'd4,
        S_GAP     = 3'd5
    } seq_state_t;

    // Forward runs radix-2 first; inverse runs radix-4 first.
    function automatic conf_t conf_decode(input seq_state_t s, input logic inv);
        conf_t c;
        c = CONF_IDLE;
        case (s)
            S_RUN_A:   c = inv ? CONF_R4_INTT      : CONF_R2_NTT;
            S_DRAIN_A: c = inv ? CONF_DONE_R4_INTT : CONF_DONE_R2_NTT;
            S_RUN_B:   c = inv ? CONF_R2_INTT      : CONF_R4_NTT;
            S_DRAIN_B: c = inv ? CONF_DONE_R2_INTT : CONF_DONE_R4_NTT;
            default:   c = CONF_IDLE;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] stage_decode(input seq_state_t s);
        logic [1:0] id;
        id = 2'd0;
        case (s)
            S_RUN_A, S_DRAIN_A: id = 2'd1;
            S_RUN_B, S_DRAIN_B: id = 2'd2;
            S_GAP:              id = 2'd3;
            default:            id = 2'd0;
        endcase
        return id;
    endfunction

    function automatic flag_t expect_flag(input seq_state_t s, input logic inv);
        flag_t f;
        f = DF_NONE;
        case (s)
            S_RUN_A: f = inv ? DF_R4_INTT : DF_R2_NTT;
            S_RUN_B: f = inv ? DF_R2_INTT : DF_R4_NTT;
            default: f = DF_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ntt_conf_sequencer_if.sv
// Request/status and stage-FSM signals of the NTT operation sequencer.
interface ntt_conf_sequencer_if;
    import ntt_ctrl_pkg::*;

    logic       start;
    logic       mode;
    logic       abort;
    flag_t      done_flag;
    conf_t      conf;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] stage_id;

    modport master (
        output start, mode, abort, done_flag,
        input  conf, busy, done, err, stage_id
    );

    modport slave (
        input  start, mode, abort, done_flag,
        output conf, busy, done, err, stage_id
    );
endinterface

// File: rtl/ntt_conf_sequencer_counter.sv
// Cycle counter with synchronous clear, increment enable and limit compare.
module seq_cycle_counter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);
endmodule

// File: rtl/ntt_conf_sequencer.sv
// Operation sequencer: walks the stage FSM through the radix-2/radix-4 stages of
// a 512-point NTT or INTT, with drain holds, abort and a per-stage watchdog.
module ntt_conf_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_R2 = 10,
    parameter int unsigned DRAIN_R4 = 16,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    ntt_conf_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIM_R2 = CNT_W'(DRAIN_R2 - 1);
    localparam logic [CNT_W-1:0] LIM_R4 = CNT_W'(DRAIN_R4 - 1);
    localparam logic [CNT_W-1:0] LIM_TO = CNT_W'(TIMEOUT - 1);

    seq_state_t       state, state_n;
    logic             mode_q, mode_n;
    logic             cnt_clr, cnt_inc, cnt_hit;
    logic [CNT_W-1:0] cnt_limit;
    logic             done_n, err_n;

    // Drain and watchdog never run together, so one counter serves both.
    seq_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .hit   (cnt_hit)
    );

    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_limit = LIM_TO;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start && !bus.abort) begin
                    state_n = S_RUN_A;
                    mode_n  = bus.mode;
                end
            end
            S_RUN_A, S_RUN_B: begin
                cnt_limit = LIM_TO;
                if (bus.done_flag == expect_flag(state, mode_q)) begin
                    state_n = (state == S_RUN_A) ? S_DRAIN_A : S_DRAIN_B;
                    cnt_clr = 1'b1;
                end else if (cnt_hit) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN_A: begin
                // Drain length follows the radix of the stage that just finished.
                cnt_limit = mode_q ? LIM_R4 : LIM_R2;
                if (cnt_hit) begin
                    state_n = S_RUN_B;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN_B: begin
                cnt_limit = mode_q ? LIM_R2 : LIM_R4;
                if (cnt_hit) begin
                    state_n = S_GAP;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_GAP: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                cnt_clr = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        if (bus.abort && state != S_IDLE) begin
            state_n = S_IDLE;
            done_n  = 1'b0;
            err_n   = 1'b0;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            bus.conf     <= CONF_IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.stage_id <= 2'd0;
        end else begin
            state        <= state_n;
            mode_q       <= mode_n;
            bus.conf     <= conf_decode(state_n, mode_n);
            bus.busy     <= (state_n != S_IDLE);
            bus.done     <= done_n;
            bus.err      <= err_n;
            bus.stage_id <= stage_decode(state_n);
        end
    end
endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Directed bench for ntt_conf_sequencer with a behavioural stage-FSM stub
// that answers each run conf with its done_flag after a set latency.
module tb_ntt_conf_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ntt_conf_sequencer_if bus ();

    ntt_conf_sequencer #(
        .DRAIN_R2 (10),
        .DRAIN_R4 (16),
        .TIMEOUT  (1024),
        .CNT_W    (11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [3:0]  seg_val   [32];
    int unsigned seg_len   [32];
    logic [1:0]  seg_stage [32];
    int unsigned nseg;
    int unsigned busy_cnt, done_cnt, err_cnt, both_cnt;
    logic        done_busy, err_busy, ev_hit;
    logic [3:0]  err_conf;

    int          lat_r2, lat_r4, wrong_n;
    logic        stub_never;
    logic [3:0]  stub_conf;
    int          stub_cnt;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int rc, lat;
        @(posedge clk);
        #1;
        if (nseg == 0 || bus.conf != seg_val[nseg-1]) begin
            if (nseg < 32) begin
                seg_val[nseg]   = bus.conf;
                seg_len[nseg]   = 1;
                seg_stage[nseg] = bus.stage_id;
                nseg++;
            end
        end else begin
            seg_len[nseg-1]++;
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin done_cnt++; done_busy = bus.busy; end
        if (bus.err) begin err_cnt++; err_busy = bus.busy; err_conf = bus.conf; end
        if (bus.done && bus.err) both_cnt++;
        // Stage-FSM stub
        rc = 0; lat = 0;
        case (bus.conf)
            4'b0001: begin rc = 1; lat = lat_r2; end
            4'b0010: begin rc = 2; lat = lat_r4; end
            4'b0101: begin rc = 3; lat = lat_r4; end
            4'b0110: begin rc = 4; lat = lat_r2; end
            default: begin rc = 0; lat = 0; end
        endcase
        if (rc != 0) begin
            if (bus.conf == stub_conf) stub_cnt++;
            else begin stub_conf = bus.conf; stub_cnt = 1; end
        end else begin
            stub_conf = 4'b0000;
            stub_cnt  = 0;
        end
        bus.done_flag = 3'b000;
        if (rc != 0 && !stub_never) begin
            if (stub_cnt >= lat) bus.done_flag = 3'(rc);
            else if (rc == 1 && wrong_n > 0 && stub_cnt >= lat - wrong_n) bus.done_flag = 3'b010;
        end
    endtask

    task automatic clear_trace();
        nseg = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
        done_busy = 1'b1; err_busy = 1'b1; err_conf = 4'hf; ev_hit = 1'b0;
    endtask

    // ev_kind: 0 none, 1 abort, 2 reset; fired when the current conf segment
    // has value ev_conf and has lasted ev_len cycles.
    task automatic run_op(input logic m, input int inject_at, input logic [3:0] ev_conf,
                          input int unsigned ev_len, input int ev_kind, input int budget);
        clear_trace();
        bus.mode  = m;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (done_cnt != 0 || err_cnt != 0) break;
            if (ev_kind != 0 && nseg > 0 && seg_val[nseg-1] == ev_conf && seg_len[nseg-1] == ev_len) begin
                if (ev_kind == 1) bus.abort = 1'b1;
                else rst = 1'b1;
                cycle();
                bus.abort = 1'b0;
                rst = 1'b0;
                ev_hit = 1'b1;
                break;
            end
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
            end
            cycle();
            bus.start = 1'b0;
        end
    endtask

    task automatic check_seq(input string tag,
                             input logic [3:0] v0, input int unsigned l0,
                             input logic [3:0] v1, input int unsigned l1,
                             input logic [3:0] v2, input int unsigned l2,
                             input logic [3:0] v3, input int unsigned l3);
        check({tag, "_nseg"}, nseg, 5);
        check({tag, "_v0"}, seg_val[0], v0);
        check({tag, "_l0"}, seg_len[0], l0);
        check({tag, "_v1"}, seg_val[1], v1);
        check({tag, "_l1"}, seg_len[1], l1);
        check({tag, "_v2"}, seg_val[2], v2);
        check({tag, "_l2"}, seg_len[2], l2);
        check({tag, "_v3"}, seg_val[3], v3);
        check({tag, "_l3"}, seg_len[3], l3);
        check({tag, "_v4"}, seg_val[4], 4'b0000);
        check({tag, "_stage_b"}, seg_stage[2], 2);
        check({tag, "_stage_gap"}, seg_stage[4], 3);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_busy_cnt"}, busy_cnt, l0 + l1 + l2 + l3 + 1);
        check({tag, "_busy_at_done"}, done_busy, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_conf"}, bus.conf, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_stage"}, bus.stage_id, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0; bus.done_flag = 3'b000;
        lat_r2 = 130; lat_r4 = 300; wrong_n = 0; stub_never = 1'b0;
        stub_conf = 4'b0000; stub_cnt = 0;
        clear_trace();
        repeat (3) cycle();
        rst = 1'b0;
        check_idle("reset");

        // abort beats a simultaneous start in idle
        bus.abort = 1'b1; bus.start = 1'b1;
        cycle();
        bus.abort = 1'b0; bus.start = 1'b0;
        check_idle("idle_abort_start");

        run_op(1'b0, -1, 4'h0, 0, 0, 2000);
        repeat (3) cycle();
        check_seq("ntt", 4'b0001, 130, 4'b0011, 10, 4'b0010, 300, 4'b0100, 16);
        check("ntt_both", both_cnt, 0);

        run_op(1'b1, -1, 4'h0, 0, 0, 2000);
        repeat (3) cycle();
        check_seq("intt", 4'b0101, 300, 4'b1000, 16, 4'b0110, 130, 4'b0111, 10);

        lat_r2 = 20; lat_r4 = 30; wrong_n = 5;
        run_op(1'b0, -1, 4'h0, 0, 0, 2000);
        repeat (3) cycle();
        check_seq("wrong", 4'b0001, 20, 4'b0011, 10, 4'b0010, 30, 4'b0100, 16);
        wrong_n = 0;

        stub_never = 1'b1;
        run_op(1'b0, -1, 4'h0, 0, 0, 1100);
        repeat (3) cycle();
        check("wd_v0", seg_val[0], 4'b0001);
        check("wd_l0", seg_len[0], 1024);
        check("wd_err_cnt", err_cnt, 1);
        check("wd_done_cnt", done_cnt, 0);
        check("wd_err_conf", err_conf, 0);
        check("wd_err_busy", err_busy, 0);
        stub_never = 1'b0;

        lat_r2 = 4; lat_r4 = 30;
        run_op(1'b0, -1, 4'b0011, 10, 1, 200);
        check("abort_hit", ev_hit, 1);
        check_idle("abort");
        bus.mode = 1'b0; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check("abort_restart_conf", bus.conf, 4'b0001);
        check("abort_restart_busy", bus.busy, 1);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        repeat (3) cycle();
        check_idle("abort_run");
        check("abort_done_cnt", done_cnt, 0);
        check("abort_err_cnt", err_cnt, 0);

        run_op(1'b0, -1, 4'b0010, 20, 2, 400);
        check("reset_hit", ev_hit, 1);
        check_idle("reset_run_b");

        lat_r2 = 130; lat_r4 = 300;
        run_op(1'b0, 50, 4'h0, 0, 0, 2000);
        repeat (5) cycle();
        check_seq("busy_start", 4'b0001, 130, 4'b0011, 10, 4'b0010, 300, 4'b0100, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
